// File: rtl/crc_check_pkg.sv
// rtl/crc_check_pkg.sv - shared PID, state and CRC constants for the packet checker
// Holds the PID encodings, the packet class and FSM state enums, the CRC
// polynomials, init values and good residues, and the body lengths per class.
package crc_check_pkg;

    typedef enum logic [3:0] {
        PID_NONE  = 4'b0000,
        PID_OUT   = 4'b0001,
        PID_ACK   = 4'b0010,
        PID_DATA0 = 4'b0011,
        PID_IN    = 4'b1001,
        PID_NAK   = 4'b1010,
        PID_DATA1 = 4'b1011,
        PID_SETUP = 4'b1101
    } pid_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_BODY,
        ST_CHECK
    } state_e;

    typedef enum logic [1:0] {
        CLS_HANDSHAKE,
        CLS_TOKEN,
        CLS_DATA
    } pid_class_e;

    localparam logic [4:0]  CRC5_POLY     = 5'b00101;
    localparam logic [4:0]  CRC5_INIT     = 5'b11111;
    localparam logic [4:0]  CRC5_RESIDUE  = 5'b01100;
    localparam logic [15:0] CRC16_POLY    = 16'h8005;
    localparam logic [15:0] CRC16_INIT    = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUE = 16'h800D;

    localparam int TOKEN_BITS = 16;
    localparam int DATA_BITS  = 80;

    // Bit 0 arrives first: seven zeros then a one.
    localparam logic [7:0] SYNC_PATTERN = 8'h80;

    function automatic logic pid_known(input logic [3:0] p);
        case (p)
            PID_OUT, PID_IN, PID_SETUP,
            PID_DATA0, PID_DATA1,
            PID_ACK, PID_NAK:       return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    // Unknown PIDs fall back to the handshake class (zero-length body).
    function automatic pid_class_e pid_class(input logic [3:0] p);
        case (p)
            PID_OUT, PID_IN, PID_SETUP: return CLS_TOKEN;
            PID_DATA0, PID_DATA1:       return CLS_DATA;
            default:                    return CLS_HANDSHAKE;
        endcase
    endfunction

    function automatic logic [6:0] expected_bits(input pid_class_e c);
        case (c)
            CLS_TOKEN: return 7'(TOKEN_BITS);
            CLS_DATA:  return 7'(DATA_BITS);
            default:   return 7'd0;
        endcase
    endfunction

endpackage

// File: rtl/crc_check_lfsr.sv
// rtl/crc_check_lfsr.sv - bit-serial CRC shift register, width and polynomial set by parameter
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (register resets to INIT)
//   load       : reload INIT (takes priority over shift)
//   shift      : advance one bit using din
//   din        : serial data bit
//   crc        : current register contents
module crc_lfsr #(
    parameter int               WIDTH = 5,
    parameter logic [WIDTH-1:0] POLY  = '0,
    parameter logic [WIDTH-1:0] INIT  = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic             din,
    output logic [WIDTH-1:0] crc
);

    logic fb;

    assign fb = din ^ crc[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= INIT;
        end else if (load) begin
            crc <= INIT;
        end else if (shift) begin
            crc <= {crc[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
    end

endmodule

// File: rtl/crc_check.sv
// rtl/crc_check.sv - serial packet checker: sync, PID, body length and CRC residue
// Ports:
//   clk, rst_L : clock, asynchronous active-low reset
//   inb        : unstuffed serial bit, LSB-first per field
//   recving    : high while packet bits arrive; falling edge ends the packet
//   pause      : current inb is a stuffed bit and is skipped
//   pid        : PID nibble of the last packet
//   done       : one-cycle pulse when the result is presented
//   crc_ok     : residue matched with no length or PID error (held)
//   pid_err    : sync, PID check-nibble or unknown-PID error (held)
//   len_err    : body bit count wrong for the PID class (held)
//   busy       : FSM not idle
module crc_check
    import crc_check_pkg::*;
(
    input  logic       clk,
    input  logic       rst_L,
    input  logic       inb,
    input  logic       recving,
    input  logic       pause,
    output logic [3:0] pid,
    output logic       done,
    output logic       crc_ok,
    output logic       pid_err,
    output logic       len_err,
    output logic       busy
);

    state_e     state, state_nxt;
    logic       consume;
    logic [6:0] bit_cnt;
    logic       armed;
    logic [3:0] pid_q;
    logic       crc_load;
    logic       crc_shift;
    logic [4:0]  crc5;
    logic [15:0] crc16;
    pid_class_e cls;
    logic [6:0] exp_bits;
    logic       residual_ok;
    logic       last_byte_bit;
    logic       pid_bit_err;
    logic       len_match;

    assign consume       = recving & ~pause;
    assign last_byte_bit = (bit_cnt[2:0] == 3'd7);
    assign cls           = pid_class(pid_q);
    assign exp_bits      = expected_bits(cls);
    assign len_match     = (bit_cnt == exp_bits);

    // Bits 4..7 of the PID byte must be the complement of bits 0..3.
    assign pid_bit_err = bit_cnt[2] && (inb != ~pid_q[bit_cnt[1:0]]);

    always_comb begin
        residual_ok = 1'b1;
        case (cls)
            CLS_TOKEN: residual_ok = (crc5 == CRC5_RESIDUE);
            CLS_DATA:  residual_ok = (crc16 == CRC16_RESIDUE);
            default:   residual_ok = 1'b1;
        endcase
    end

    // Both registers track every body bit; the class picks which one is judged.
    crc_lfsr #(
        .WIDTH (5),
        .POLY  (CRC5_POLY),
        .INIT  (CRC5_INIT)
    ) u_crc5 (
        .clk   (clk),
        .rst_n (rst_L),
        .load  (crc_load),
        .shift (crc_shift),
        .din   (inb),
        .crc   (crc5)
    );

    crc_lfsr #(
        .WIDTH (16),
        .POLY  (CRC16_POLY),
        .INIT  (CRC16_INIT)
    ) u_crc16 (
        .clk   (clk),
        .rst_n (rst_L),
        .load  (crc_load),
        .shift (crc_shift),
        .din   (inb),
        .crc   (crc16)
    );

    always_comb begin
        state_nxt = state;
        crc_load  = 1'b0;
        crc_shift = 1'b0;
        case (state)
            ST_IDLE: begin
                if (armed && consume) state_nxt = ST_SYNC;
            end
            ST_SYNC: begin
                if (!recving)                        state_nxt = ST_CHECK;
                else if (consume && last_byte_bit)   state_nxt = ST_PID;
            end
            ST_PID: begin
                if (!recving) begin
                    state_nxt = ST_CHECK;
                end else if (consume && last_byte_bit) begin
                    state_nxt = ST_BODY;
                    crc_load  = 1'b1;
                end
            end
            ST_BODY: begin
                if (!recving)     state_nxt = ST_CHECK;
                else if (consume) crc_shift = 1'b1;
            end
            ST_CHECK: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign done = (state == ST_CHECK);
    assign busy = (state != ST_IDLE);
    assign pid  = pid_q;

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state   <= ST_IDLE;
            bit_cnt <= 7'd0;
            armed   <= 1'b0;
            pid_q   <= 4'd0;
            crc_ok  <= 1'b0;
            pid_err <= 1'b0;
            len_err <= 1'b0;
        end else begin
            state <= state_nxt;
            // A packet may only start after recving has been seen low, so a
            // reset in mid-packet ignores the rest of that packet.
            if (!recving) armed <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (armed && consume) begin
                        armed   <= 1'b0;
                        crc_ok  <= 1'b0;
                        len_err <= 1'b0;
                        pid_q   <= 4'd0;
                        pid_err <= (inb != SYNC_PATTERN[0]);
                        bit_cnt <= 7'd1;
                    end
                end
                ST_SYNC: begin
                    if (!recving) begin
                        pid_err <= 1'b1;
                        len_err <= 1'b1;
                    end else if (consume) begin
                        if (inb != SYNC_PATTERN[bit_cnt[2:0]]) pid_err <= 1'b1;
                        bit_cnt <= last_byte_bit ? 7'd0 : bit_cnt + 7'd1;
                    end
                end
                ST_PID: begin
                    if (!recving) begin
                        pid_err <= 1'b1;
                        len_err <= 1'b1;
                    end else if (consume) begin
                        if (!bit_cnt[2]) pid_q[bit_cnt[1:0]] <= inb;
                        if (pid_bit_err || (last_byte_bit && !pid_known(pid_q)))
                            pid_err <= 1'b1;
                        bit_cnt <= last_byte_bit ? 7'd0 : bit_cnt + 7'd1;
                    end
                end
                ST_BODY: begin
                    if (!recving) begin
                        len_err <= !len_match;
                        crc_ok  <= residual_ok && len_match && !pid_err;
                    end else if (consume && bit_cnt != 7'h7F) begin
                        bit_cnt <= bit_cnt + 7'd1;
                    end
                end
                ST_CHECK: bit_cnt <= 7'd0;
                default:  bit_cnt <= 7'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_check.sv
// tb/tb_crc_check.sv - scoreboard bench for crc_check
module tb_crc_check;

    logic       clk = 1'b0;
    logic       rst_L = 1'b0;
    logic       inb = 1'b0;
    logic       recving = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] pid;
    logic       done;
    logic       crc_ok;
    logic       pid_err;
    logic       len_err;
    logic       busy;

    crc_check dut (
        .clk     (clk),
        .rst_L   (rst_L),
        .inb     (inb),
        .recving (recving),
        .pause   (pause),
        .pid     (pid),
        .done    (done),
        .crc_ok  (crc_ok),
        .pid_err (pid_err),
        .len_err (len_err),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string      name;
        logic [3:0] pid;
        logic       chk_pid;
        logic       ok;
        logic       perr;
        logic       lerr;
        int         done_cyc;
    } exp_t;

    exp_t sb[$];
    logic bits[$];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check({e.name, "/latency"}, cyc, e.done_cyc);
                if (e.chk_pid) check({e.name, "/pid"}, {28'd0, pid}, {28'd0, e.pid});
                check({e.name, "/crc_ok"},  {31'd0, crc_ok},  {31'd0, e.ok});
                check({e.name, "/pid_err"}, {31'd0, pid_err}, {31'd0, e.perr});
                check({e.name, "/len_err"}, {31'd0, len_err}, {31'd0, e.lerr});
            end
        end
    end

    task automatic drive(input logic r, input logic p, input logic b);
        @(posedge clk);
        #1;
        recving = r;
        pause   = p;
        inb     = b;
    endtask

    task automatic add_bits(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) bits.push_back(v[i]);
    endtask

    task automatic add_hdr(input logic [3:0] p);
        add_bits(64'h80, 8);
        add_bits({56'd0, ~p, p}, 8);
    endtask

    // Reflected (LSB-shifting) form of the USB CRCs; complement sent LSB-first.
    task automatic add_crc5(input int start);
        logic [4:0] c;
        c = 5'h1F;
        for (int i = start; i < bits.size(); i++)
            c = (c[0] ^ bits[i]) ? ((c >> 1) ^ 5'h14) : (c >> 1);
        add_bits({59'd0, ~c}, 5);
    endtask

    task automatic add_crc16(input int start);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = start; i < bits.size(); i++)
            c = (c[0] ^ bits[i]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        add_bits({48'd0, ~c}, 16);
    endtask

    task automatic send(input string name, input logic [3:0] ep, input logic cp,
                        input logic eok, input logic epe, input logic ele,
                        input logic [127:0] pmask, input logic end_pause);
        exp_t e;
        for (int i = 0; i < bits.size(); i++) begin
            if (pmask[i]) drive(1'b1, 1'b1, ~bits[i]);
            drive(1'b1, 1'b0, bits[i]);
        end
        drive(1'b0, end_pause, 1'b1);
        e.name = name; e.pid = ep; e.chk_pid = cp; e.ok = eok;
        e.perr = epe; e.lerr = ele; e.done_cyc = cyc + 1;
        sb.push_back(e);
        bits.delete();
        repeat (3) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "/pid"},     {28'd0, pid}, 32'd0);
        check({tag, "/done"},    {31'd0, done}, 32'd0);
        check({tag, "/crc_ok"},  {31'd0, crc_ok}, 32'd0);
        check({tag, "/pid_err"}, {31'd0, pid_err}, 32'd0);
        check({tag, "/len_err"}, {31'd0, len_err}, 32'd0);
        check({tag, "/busy"},    {31'd0, busy}, 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    localparam logic [63:0] PAYLOAD = 64'h0123_4567_89AB_CDEF;

    initial begin : stim
        logic [127:0] pm;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_cleared("reset");
        @(posedge clk); #1 rst_L = 1'b1;
        repeat (3) drive(1'b0, 1'b0, 1'b0);

        add_hdr(4'b0001); add_bits(64'h05, 7); add_bits(64'h2, 4); add_crc5(16);
        send("out_token", 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 128'd0, 1'b0);

        add_hdr(4'b0011); add_bits(PAYLOAD, 64); add_crc16(16);
        send("data0", 4'b0011, 1'b1, 1'b1, 1'b0, 1'b0, 128'd0, 1'b0);

        add_hdr(4'b0011); add_bits(PAYLOAD, 64); add_crc16(16);
        bits[16 + 21] = ~bits[16 + 21];
        send("data0_flip", 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0, 128'd0, 1'b0);

        add_bits(64'h80, 8); add_bits(64'hD2, 8);
        send("ack_endpause", 4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 128'd0, 1'b1);

        add_bits(64'h80, 8); add_bits(64'h52, 8);
        send("bad_check", 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 128'd0, 1'b0);

        add_hdr(4'b1011); add_bits(64'hFEDC_BA98_7654_3210, 64); add_crc16(16);
        pm = '0;
        pm[3] = 1'b1; pm[11] = 1'b1; pm[20] = 1'b1;
        pm[47] = 1'b1; pm[70] = 1'b1; pm[95] = 1'b1;
        send("data1_paused", 4'b1011, 1'b1, 1'b1, 1'b0, 1'b0, pm, 1'b0);

        add_hdr(4'b0001); add_bits(64'h105, 10);
        send("token_short", 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 128'd0, 1'b0);

        add_bits(64'h80, 8); add_bits(64'hE1, 3);
        send("drop_in_pid", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 128'd0, 1'b0);

        add_bits(64'h80, 8); add_bits(64'hF0, 8);
        send("unknown_pid", 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 128'd0, 1'b0);

        add_bits(64'h81, 8); add_bits(64'hD2, 8);
        send("bad_sync", 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 128'd0, 1'b0);

        // Reset in the middle of a DATA0 packet; the tail must be ignored.
        add_hdr(4'b0011); add_bits(PAYLOAD, 64); add_crc16(16);
        for (int i = 0; i < 40; i++) drive(1'b1, 1'b0, bits[i]);
        @(negedge clk);
        check("mid_packet/busy", {31'd0, busy}, 32'd1);
        check("mid_packet/pid",  {28'd0, pid}, 32'h3);
        rst_L = 1'b0;
        #2;
        check_cleared("mid_reset");
        @(posedge clk); #1 rst_L = 1'b1;
        for (int i = 40; i < bits.size(); i++) drive(1'b1, 1'b0, bits[i]);
        bits.delete();
        repeat (4) drive(1'b0, 1'b0, 1'b0);
        check("after_reset/idle_busy", {31'd0, busy}, 32'd0);

        add_hdr(4'b0011); add_bits(PAYLOAD, 64); add_crc16(16);
        send("data0_after_reset", 4'b0011, 1'b1, 1'b1, 1'b0, 1'b0, 128'd0, 1'b0);

        add_hdr(4'b1001); add_bits(64'h7F, 7); add_bits(64'hF, 4); add_crc5(16);
        send("in_token", 4'b1001, 1'b1, 1'b1, 1'b0, 1'b0, 128'd0, 1'b0);

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
